// File: rtl/mastermind_turn_sequencer_if.sv
// Control/status bundle between the match sequencer and the game front end.
// The front end drives the pulses (master); the sequencer answers with role and score state (slave).
interface mastermind_turn_sequencer_if #(
   parameter int MAX_GUESSES = 12,
   parameter int SCORE_W     = 8
);
   localparam int CW = $clog2(MAX_GUESSES + 1);

   logic               start;
   logic               code_entered;
   logic               guess_entered;
   logic               guess_correct;
   logic               started;
   logic               active_p;
   logic               take_code;
   logic [CW-1:0]      guess_count;
   logic [SCORE_W-1:0] score_a;
   logic [SCORE_W-1:0] score_b;
   logic               half_done;
   logic               match_over;

   modport master (
      output start, code_entered, guess_entered, guess_correct,
      input  started, active_p, take_code, guess_count, score_a, score_b, half_done, match_over
   );

   modport slave (
      input  start, code_entered, guess_entered, guess_correct,
      output started, active_p, take_code, guess_count, score_a, score_b, half_done, match_over
   );
endinterface

// File: rtl/mastermind_turn_sequencer.sv
// Match-level turn/role sequencer: picks code maker/breaker, counts guesses, scores the maker
// and swaps roles each half-round until 2*ROUNDS half-rounds have been played.
module mastermind_turn_sequencer #(
   parameter int MAX_GUESSES = 12,
   parameter int ROUNDS      = 2,
   parameter int SCORE_W     = 8
) (
   input logic                      clk,
   input logic                      reset,
   mastermind_turn_sequencer_if.slave bus
);
   localparam int CW = $clog2(MAX_GUESSES + 1);
   localparam int HW = $clog2(2 * ROUNDS + 1);
   localparam int AW = ((SCORE_W > CW) ? SCORE_W : CW) + 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MAKE  = 2'd1;
   localparam logic [1:0] S_BREAK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_GUESSES);
   localparam logic [HW-1:0] LAST_HALF = HW'(2 * ROUNDS);
   localparam logic [AW-1:0] SAT       = {{(AW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

   logic [1:0]    state_reg, state_next;
   logic          maker_reg, maker_next;
   logic [CW-1:0] guess_count_reg, guess_count_next;
   logic [HW-1:0] half_cnt_reg, half_cnt_next;
   logic          started_reg, active_p_reg, take_code_reg, half_done_reg, match_over_reg;
   logic          half_done_next, clear_scores, add_en;
   logic [CW-1:0] gc_inc;
   logic [CW:0]   score_add;
   logic          active_p_next;

   always_comb begin
      state_next       = state_reg;
      maker_next       = maker_reg;
      guess_count_next = guess_count_reg;
      half_cnt_next    = half_cnt_reg;
      half_done_next   = 1'b0;
      clear_scores     = 1'b0;
      add_en           = 1'b0;
      score_add        = '0;
      gc_inc           = guess_count_reg + 1'b1;
      case (state_reg)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_next       = S_MAKE;
               maker_next       = 1'b1;
               guess_count_next = '0;
               half_cnt_next    = '0;
               clear_scores     = 1'b1;
            end
         end
         S_MAKE: begin
            if (bus.code_entered) begin
               state_next       = S_BREAK;
               guess_count_next = '0;
            end
         end
         default: begin
            if (bus.guess_entered) begin
               guess_count_next = gc_inc;
               if (bus.guess_correct || gc_inc == MAX_CNT) begin
                  // Uncracked code earns the maker one bonus point on top of the guesses used.
                  half_done_next = 1'b1;
                  add_en         = 1'b1;
                  score_add      = {1'b0, gc_inc} + {{CW{1'b0}}, ~bus.guess_correct};
                  half_cnt_next  = half_cnt_reg + 1'b1;
                  if (half_cnt_next == LAST_HALF) begin
                     state_next = S_DONE;
                  end else begin
                     state_next = S_MAKE;
                     maker_next = ~maker_reg;
                  end
               end
            end
         end
      endcase
   end

   always_comb begin
      active_p_next = 1'b0;
      if (state_next == S_MAKE)       active_p_next = maker_next;
      else if (state_next == S_BREAK) active_p_next = ~maker_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_IDLE;
         maker_reg       <= 1'b1;
         guess_count_reg <= '0;
         half_cnt_reg    <= '0;
         started_reg     <= 1'b0;
         active_p_reg    <= 1'b0;
         take_code_reg   <= 1'b0;
         half_done_reg   <= 1'b0;
         match_over_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         maker_reg       <= maker_next;
         guess_count_reg <= guess_count_next;
         half_cnt_reg    <= half_cnt_next;
         started_reg     <= (state_next == S_MAKE) || (state_next == S_BREAK);
         active_p_reg    <= active_p_next;
         take_code_reg   <= (state_next == S_MAKE);
         half_done_reg   <= half_done_next;
         match_over_reg  <= (state_next == S_DONE);
      end
   end

   // gi=1 is player A, gi=0 is player B; only the current maker's register accumulates.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_score
         logic [SCORE_W-1:0] score_reg;
         logic [AW-1:0]      sum;
         assign sum = AW'(score_reg) + AW'(score_add);
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               score_reg <= '0;
            end else if (clear_scores) begin
               score_reg <= '0;
            end else if (add_en && (maker_reg == 1'(gi))) begin
               score_reg <= (sum > SAT) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
            end
         end
      end
   endgenerate

   assign bus.started     = started_reg;
   assign bus.active_p    = active_p_reg;
   assign bus.take_code   = take_code_reg;
   assign bus.guess_count = guess_count_reg;
   assign bus.score_a     = g_score[1].score_reg;
   assign bus.score_b     = g_score[0].score_reg;
   assign bus.half_done   = half_done_reg;
   assign bus.match_over  = match_over_reg;
endmodule

// File: tb/tb_mastermind_turn_sequencer.sv
// Directed bench for the turn sequencer: main instance (SCORE_W=8) plus a SCORE_W=4 instance for saturation.
module tb_mastermind_turn_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mastermind_turn_sequencer_if #(.MAX_GUESSES(12), .SCORE_W(8)) bus ();
   mastermind_turn_sequencer_if #(.MAX_GUESSES(12), .SCORE_W(4)) bus4 ();

   mastermind_turn_sequencer #(.MAX_GUESSES(12), .ROUNDS(2), .SCORE_W(8)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   mastermind_turn_sequencer #(.MAX_GUESSES(12), .ROUNDS(2), .SCORE_W(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4)
   );

   // Inputs held high across exactly one rising edge; returns at the following falling edge.
   task automatic pulse(input logic s, input logic c, input logic g, input logic gc);
      @(negedge clk);
      bus.start = s; bus.code_entered = c; bus.guess_entered = g; bus.guess_correct = gc;
      @(negedge clk);
      bus.start = 1'b0; bus.code_entered = 1'b0; bus.guess_entered = 1'b0; bus.guess_correct = 1'b0;
      $display("txn s=%0b c=%0b g=%0b gc=%0b -> started=%0b act=%0b take=%0b cnt=%0d sa=%0d sb=%0d hd=%0b mo=%0b",
               s, c, g, gc, bus.started, bus.active_p, bus.take_code, bus.guess_count,
               bus.score_a, bus.score_b, bus.half_done, bus.match_over);
   endtask

   task automatic pulse4(input logic s, input logic c, input logic g, input logic gc);
      @(negedge clk);
      bus4.start = s; bus4.code_entered = c; bus4.guess_entered = g; bus4.guess_correct = gc;
      @(negedge clk);
      bus4.start = 1'b0; bus4.code_entered = 1'b0; bus4.guess_entered = 1'b0; bus4.guess_correct = 1'b0;
      $display("txn4 s=%0b c=%0b g=%0b gc=%0b -> cnt=%0d sa=%0d sb=%0d hd=%0b",
               s, c, g, gc, bus4.guess_count, bus4.score_a, bus4.score_b, bus4.half_done);
   endtask

   task automatic test_reset();
      logic [29:0] outs;
      repeat (2) @(negedge clk);
      outs = {bus.started, bus.active_p, bus.take_code, bus.guess_count, bus.score_a, bus.score_b,
              bus.half_done, bus.match_over};
      checks++;
      if (outs !== 30'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
      reset = 1'b1;
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      pulse(0, 0, 1, 0);
      checks++;
      if (bus.guess_count !== 4'd1) begin fails++; $display("FAIL pre_reset_count: got %0d want 1", bus.guess_count); end
      #2 reset = 1'b0;
      #1;
      outs = {bus.started, bus.active_p, bus.take_code, bus.guess_count, bus.score_a, bus.score_b,
              bus.half_done, bus.match_over};
      checks++;
      if (outs !== 30'd0) begin fails++; $display("FAIL midmatch_reset: got %h want 0", outs); end
      @(negedge clk);
      reset = 1'b1;
      pulse(1, 0, 0, 0);
      checks++;
      if ({bus.started, bus.active_p, bus.take_code} !== 3'b111) begin
         fails++; $display("FAIL start_after_reset: got %b want 111", {bus.started, bus.active_p, bus.take_code});
      end
   endtask

   task automatic test_first_half();
      pulse(0, 1, 0, 0);
      checks++;
      if ({bus.started, bus.active_p, bus.take_code} !== 3'b100) begin
         fails++; $display("FAIL a_makes_break_roles: got %b want 100", {bus.started, bus.active_p, bus.take_code});
      end
      pulse(0, 0, 1, 0);
      pulse(0, 0, 1, 0);
      pulse(0, 0, 1, 1);
      checks++;
      if (bus.guess_count !== 4'd3 || bus.score_a !== 8'd3 || bus.score_b !== 8'd0) begin
         fails++; $display("FAIL cracked_half: got cnt=%0d sa=%0d sb=%0d want 3/3/0", bus.guess_count, bus.score_a, bus.score_b);
      end
      checks++;
      if ({bus.half_done, bus.started, bus.active_p, bus.take_code} !== 4'b1101) begin
         fails++; $display("FAIL swap_to_b: got %b want 1101", {bus.half_done, bus.started, bus.active_p, bus.take_code});
      end
      @(negedge clk);
      checks++;
      if (bus.half_done !== 1'b0) begin fails++; $display("FAIL half_done_width: got %b want 0", bus.half_done); end
   endtask

   task automatic test_fail_half();
      pulse(0, 1, 0, 0);
      checks++;
      if ({bus.active_p, bus.take_code, bus.guess_count} !== 6'b100000) begin
         fails++; $display("FAIL b_makes_roles: got %b want 100000", {bus.active_p, bus.take_code, bus.guess_count});
      end
      for (int i = 0; i < 11; i++) pulse(0, 0, 1, 0);
      checks++;
      if (bus.guess_count !== 4'd11 || bus.half_done !== 1'b0 || bus.take_code !== 1'b0) begin
         fails++; $display("FAIL eleven_guesses: got cnt=%0d hd=%b take=%b want 11/0/0", bus.guess_count, bus.half_done, bus.take_code);
      end
      pulse(0, 0, 1, 0);
      checks++;
      if (bus.guess_count !== 4'd12 || bus.score_b !== 8'd13 || bus.score_a !== 8'd3) begin
         fails++; $display("FAIL failed_half_score: got cnt=%0d sb=%0d sa=%0d want 12/13/3", bus.guess_count, bus.score_b, bus.score_a);
      end
      checks++;
      if ({bus.half_done, bus.active_p, bus.take_code} !== 3'b111) begin
         fails++; $display("FAIL swap_to_a: got %b want 111", {bus.half_done, bus.active_p, bus.take_code});
      end
   endtask

   task automatic test_ignored();
      pulse(0, 0, 1, 1);
      checks++;
      if ({bus.started, bus.active_p, bus.take_code} !== 3'b111 || bus.guess_count !== 4'd12) begin
         fails++; $display("FAIL guess_in_make: got roles=%b cnt=%0d want 111/12", {bus.started, bus.active_p, bus.take_code}, bus.guess_count);
      end
      pulse(1, 0, 0, 0);
      checks++;
      if (bus.take_code !== 1'b1 || bus.score_a !== 8'd3 || bus.score_b !== 8'd13) begin
         fails++; $display("FAIL start_in_make: got take=%b sa=%0d sb=%0d want 1/3/13", bus.take_code, bus.score_a, bus.score_b);
      end
      pulse(0, 1, 0, 0);
      pulse(0, 1, 0, 0);
      pulse(1, 0, 0, 0);
      pulse(0, 0, 0, 1);
      checks++;
      if ({bus.started, bus.active_p, bus.take_code} !== 3'b100 || bus.guess_count !== 4'd0 || bus.score_b !== 8'd13) begin
         fails++; $display("FAIL noise_in_break: got roles=%b cnt=%0d sb=%0d want 100/0/13",
                           {bus.started, bus.active_p, bus.take_code}, bus.guess_count, bus.score_b);
      end
      pulse(1, 1, 1, 1);
      checks++;
      if (bus.guess_count !== 4'd1 || bus.score_a !== 8'd4 || {bus.half_done, bus.active_p, bus.take_code} !== 3'b101) begin
         fails++; $display("FAIL simultaneous_pulses: got cnt=%0d sa=%0d hd/act/take=%b want 1/4/101",
                           bus.guess_count, bus.score_a, {bus.half_done, bus.active_p, bus.take_code});
      end
   endtask

   task automatic test_full_match();
      pulse(0, 1, 0, 0);
      pulse(0, 0, 1, 1);
      checks++;
      if ({bus.half_done, bus.match_over, bus.started, bus.active_p, bus.take_code} !== 5'b11000) begin
         fails++; $display("FAIL match_end_flags: got %b want 11000",
                           {bus.half_done, bus.match_over, bus.started, bus.active_p, bus.take_code});
      end
      checks++;
      if (bus.score_a !== 8'd4 || bus.score_b !== 8'd14 || bus.guess_count !== 4'd1) begin
         fails++; $display("FAIL final_scores: got sa=%0d sb=%0d cnt=%0d want 4/14/1", bus.score_a, bus.score_b, bus.guess_count);
      end
      pulse(0, 1, 1, 0);
      checks++;
      if (bus.match_over !== 1'b1 || bus.half_done !== 1'b0 || bus.score_b !== 8'd14) begin
         fails++; $display("FAIL done_holds: got mo=%b hd=%b sb=%0d want 1/0/14", bus.match_over, bus.half_done, bus.score_b);
      end
      pulse(1, 0, 0, 0);
      checks++;
      if (bus.match_over !== 1'b0 || bus.score_a !== 8'd0 || bus.score_b !== 8'd0 ||
          {bus.started, bus.active_p, bus.take_code} !== 3'b111 || bus.guess_count !== 4'd0) begin
         fails++; $display("FAIL restart_from_done: got mo=%b sa=%0d sb=%0d roles=%b cnt=%0d want 0/0/0/111/0",
                           bus.match_over, bus.score_a, bus.score_b, {bus.started, bus.active_p, bus.take_code}, bus.guess_count);
      end
      pulse(0, 1, 0, 0);
      for (int i = 0; i < 11; i++) pulse(0, 0, 1, 0);
      pulse(0, 0, 1, 1);
      checks++;
      if (bus.score_a !== 8'd12 || bus.guess_count !== 4'd12 || bus.half_done !== 1'b1) begin
         fails++; $display("FAIL cracked_on_last: got sa=%0d cnt=%0d hd=%b want 12/12/1", bus.score_a, bus.guess_count, bus.half_done);
      end
   endtask

   task automatic test_saturation();
      pulse4(1, 0, 0, 0);
      pulse4(0, 1, 0, 0);
      for (int i = 0; i < 12; i++) pulse4(0, 0, 1, 0);
      checks++;
      if (bus4.score_a !== 4'd13) begin fails++; $display("FAIL sat_first_half: got %0d want 13", bus4.score_a); end
      pulse4(0, 1, 0, 0);
      pulse4(0, 0, 1, 1);
      pulse4(0, 1, 0, 0);
      for (int i = 0; i < 12; i++) pulse4(0, 0, 1, 0);
      checks++;
      if (bus4.score_a !== 4'd15 || bus4.score_b !== 4'd1) begin
         fails++; $display("FAIL score_saturates: got sa=%0d sb=%0d want 15/1", bus4.score_a, bus4.score_b);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.code_entered = 1'b0; bus.guess_entered = 1'b0; bus.guess_correct = 1'b0;
      bus4.start = 1'b0; bus4.code_entered = 1'b0; bus4.guess_entered = 1'b0; bus4.guess_correct = 1'b0;
      test_reset();
      test_first_half();
      test_fail_half();
      test_ignored();
      test_full_match();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
